// File: rtl/rf_arb_pkg.sv
// ============================================================================
// rf_arb_pkg : shared widths, write-record type and arbiter state encoding
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rf_arb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rf_wq.sv
// ============================================================================
// rf_wq    : DEPTH-entry write queue with per-entry source-address compare
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_wq
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  rf_wr_t                push_wr,
  input  logic                  pop,
  input  logic [RF_AW-1:0]      rd_a,
  input  logic [RF_AW-1:0]      rd_b,
  output rf_wr_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                  pend_a,
  output logic                  pend_b
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;

  rf_wr_t            mem_q [DEPTH];
  rf_wr_t            mem_d [DEPTH];
  logic [c_pw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]   count_q, count_d;
  logic [DEPTH-1:0]  w_hit_a, w_hit_b;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + c_cw'(push) - c_cw'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_wr;
      wr_ptr_d        = wr_ptr_q + c_pw'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [c_pw-1:0] w_off;
    logic            w_valid;
    assign w_off      = c_pw'(i) - rd_ptr_q;
    assign w_valid    = ({1'b0, w_off} < count_q);
    assign w_hit_a[i] = w_valid && (mem_q[i].addr == rd_a);
    assign w_hit_b[i] = w_valid && (mem_q[i].addr == rd_b);
  end

  assign pend_a = (rd_a != '0) && (|w_hit_a);
  assign pend_b = (rd_b != '0) && (|w_hit_b);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

`default_nettype wire

// File: rtl/rf_wr_arb.sv
// ============================================================================
// rf_wr_arb : register-file write-port arbiter (writeback vs. queued mul/div)
//             RF_ARB_STARVE_EN adds the age counter and forced HOLD cycle.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rf_wr_arb
  import rf_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [RF_AW-1:0] wb_addr,
  input  logic [RF_DW-1:0] wb_data,
  input  logic             md_valid,
  input  logic [RF_AW-1:0] md_addr,
  input  logic [RF_DW-1:0] md_data,
  output logic             md_ready,
  output logic             RFWr,
  output logic [RF_AW-1:0] W,
  output logic [RF_DW-1:0] din,
  input  logic [RF_AW-1:0] rd_a,
  input  logic [RF_AW-1:0] rd_b,
  output logic             pend_a,
  output logic             pend_b,
  output logic             wb_hold
);

  localparam int c_cw = $clog2(DEPTH) + 1;

  arb_state_e      state_q, state_d;
  rf_wr_t          w_head;
  rf_wr_t          w_push_wr;
  logic [c_cw-1:0] w_count, w_cnt_nxt;
  logic            w_empty, w_push, w_hold, w_head_gnt, w_wb_gnt, w_hold_trig;
  logic            w_pend_a, w_pend_b;

  assign w_push_wr  = '{addr: md_addr, data: md_data};
  assign w_empty    = (w_count == '0);
  assign md_ready   = !rst && (w_count < c_cw'(DEPTH));
  assign w_push     = md_valid && md_ready;
  assign w_hold     = (state_q == HOLD);
  assign w_head_gnt = !w_empty && (w_hold || !wb_we);
  assign w_wb_gnt   = wb_we && !w_hold;

  rf_wq #(.DEPTH(DEPTH)) u_wq (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .push_wr (w_push_wr),
    .pop     (w_head_gnt),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .head    (w_head),
    .count   (w_count),
    .pend_a  (w_pend_a),
    .pend_b  (w_pend_b)
  );

  always_comb begin
    RFWr = 1'b0;
    W    = '0;
    din  = '0;
    if (!rst) begin
      if (w_wb_gnt) begin
        W   = wb_addr;
        din = wb_data;
      end else if (w_head_gnt) begin
        W   = w_head.addr;
        din = w_head.data;
      end
      // Register 0 is hardwired; a granted write to it is consumed silently.
      RFWr = (w_wb_gnt || w_head_gnt) && (W != '0);
    end
  end

  assign pend_a  = !rst && w_pend_a;
  assign pend_b  = !rst && w_pend_b;
  assign wb_hold = !rst && w_hold;

`ifdef RF_ARB_STARVE_EN
  localparam int c_age_w = $clog2(MAX_WAIT + 1);

  logic [c_age_w-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q + c_age_w'(1);
    if (w_empty || w_head_gnt) begin
      age_d = '0;
    end
  end

  assign w_hold_trig = (age_d == c_age_w'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Strict priority: the starvation trigger can never fire.
  assign w_hold_trig = (MAX_WAIT < 0);
`endif

  always_comb begin
    w_cnt_nxt = w_count + c_cw'(w_push) - c_cw'(w_head_gnt);
    state_d   = EMPTY;
    if (w_hold_trig) begin
      state_d = HOLD;
    end else if (w_cnt_nxt != '0) begin
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arb.sv
// ============================================================================
// tb_rf_wr_arb : directed + random stimulus against a queue-based reference
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_rf_wr_arb;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        RFWr;
  logic [4:0]  W;
  logic [31:0] din;
  logic [4:0]  rd_a;
  logic [4:0]  rd_b;
  logic        pend_a;
  logic        pend_b;
  logic        wb_hold;

  always #5 clk = ~clk;

  rf_wr_arb #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_ready (md_ready),
    .RFWr     (RFWr),
    .W        (W),
    .din      (din),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .wb_hold  (wb_hold)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_hold = 1'b0;
  int   m_age  = 0;

  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                      input logic [31:0] md, input logic [4:0] ra, input logic [4:0] rb);
    bit          e_gh, e_gw, e_we, e_rdy, e_pa, e_pb, e_hold, nonempty;
    logic [4:0]  e_w;
    logic [31:0] e_d;
    ent_t        e;
    @(negedge clk);
    rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md; rd_a = ra; rd_b = rb;
    #1;
    e_gh = 0; e_gw = 0; e_we = 0; e_rdy = 0; e_pa = 0; e_pb = 0; e_hold = 0;
    e_w = '0; e_d = '0;
    if (!r) begin
      e_hold = m_hold;
      e_rdy  = (mq.size() < DEPTH);
      e_gh   = (mq.size() != 0) && (m_hold || !we);
      e_gw   = we && !m_hold;
      if (e_gw) begin
        e_w = wa; e_d = wd;
      end else if (e_gh) begin
        e_w = mq[0].a; e_d = mq[0].d;
      end
      e_we = (e_gw || e_gh) && (e_w != 0);
      foreach (mq[k]) begin
        if (ra != 0 && mq[k].a == ra) e_pa = 1;
        if (rb != 0 && mq[k].a == rb) e_pb = 1;
      end
    end
    check_eq("RFWr", 32'(RFWr), 32'(e_we));
    check_eq("W", 32'(W), 32'(e_w));
    check_eq("din", din, e_d);
    check_eq("md_ready", 32'(md_ready), 32'(e_rdy));
    check_eq("pend_a", 32'(pend_a), 32'(e_pa));
    check_eq("pend_b", 32'(pend_b), 32'(e_pb));
    check_eq("wb_hold", 32'(wb_hold), 32'(e_hold));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_hold = 0;
      m_age  = 0;
    end else begin
      nonempty = (mq.size() != 0);
      if (e_gh) void'(mq.pop_front());
      if (mv && e_rdy) begin
        e.a = ma; e.d = md;
        mq.push_back(e);
      end
      if (nonempty && !e_gh) m_age++;
      else m_age = 0;
`ifdef RF_ARB_STARVE_EN
      m_hold = (m_age == MAX_WAIT);
`else
      m_hold = 0;
`endif
    end
  endtask

  task automatic idle(input logic [4:0] ra);
    step(0, 0, 0, 0, 0, 0, 0, ra, 0);
  endtask

  initial begin
    int p_we;
    rst = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0; rd_a = 0; rd_b = 0;

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // single push, one-cycle latency, pend visible only while queued
    step(0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 0);
    idle(5'd5);
    idle(5'd5);

    // writeback saturating the port while two entries queue up
    step(0, 1, 5'd9, 32'h1111, 1, 5'd3, 32'h3333, 5'd3, 5'd4);
    step(0, 1, 5'd9, 32'h1112, 1, 5'd4, 32'h4444, 5'd3, 5'd4);
    step(0, 1, 5'd9, 32'h1113, 1, 5'd6, 32'h6666, 5'd3, 5'd4);
    step(0, 1, 5'd9, 32'h1114, 0, 0, 0, 5'd3, 5'd4);
    repeat (3) idle(5'd4);

    // address-0 entry pops without writing
    step(0, 0, 0, 0, 1, 5'd0, 32'hABCD, 5'd0, 0);
    idle(5'd0);
    idle(5'd0);

    // starvation candidate under continuous writeback
    step(0, 1, 5'd2, 32'h2222, 1, 5'd7, 32'h7777, 5'd7, 0);
    repeat (8) step(0, 1, 5'd2, 32'h2222, 0, 0, 0, 5'd7, 0);
    repeat (2) idle(5'd7);

    // fill, then steady push/pop to walk the pointers around
    step(0, 1, 5'd1, 32'h1, 1, 5'd10, 32'hA0, 5'd10, 5'd11);
    step(0, 1, 5'd1, 32'h2, 1, 5'd11, 32'hA1, 5'd10, 5'd11);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 5'(12 + i), 32'hB0 + i, 5'(12 + i), 5'd11);
    repeat (3) idle(0);

    // reset with two entries queued
    step(0, 1, 5'd1, 32'h5, 1, 5'd20, 32'hC0, 0, 0);
    step(0, 1, 5'd1, 32'h6, 1, 5'd21, 32'hC1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
    repeat (3) idle(5'd20);

    for (int i = 0; i < 1500; i++) begin
      p_we = (i < 500) ? 30 : ((i < 1000) ? 70 : 95);
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < p_we),
           5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 50),
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
